// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared widths, FSM state and command types for the data-memory arbiter
package dmem_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 12;
  localparam int BUS_W_DEF  = 17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // One memory command as seen at the default widths
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } dmem_cmd_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core-array and memory-port bundle around the arbiter
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUS_W     = BUS_W_DEF
);
  localparam int IDX_W = $clog2(NUM_CORES);

  logic [NUM_CORES-1:0]        core_req;
  logic [NUM_CORES-1:0]        core_we;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0]        core_ack;
  logic [DATA_W-1:0]           core_rdata;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [BUS_W-1:0]            mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;
  logic                        busy;
  logic [IDX_W-1:0]            grant_id;

  // Arbiter side
  modport master (
    input  core_req, core_we, core_addr, core_wdata, mem_rdata,
    output core_ack, core_rdata, mem_we, mem_addr, mem_wdata, busy, grant_id
  );

  // Cores and memory side
  modport slave (
    output core_req, core_we, core_addr, core_wdata, mem_rdata,
    input  core_ack, core_rdata, mem_we, mem_addr, mem_wdata, busy, grant_id
  );

endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner select (rotate, priority-encode, un-rotate)
module rr_picker #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDX_W:0] off;
  logic [IDX_W:0] sum;

  // Rotate so rr_ptr lands at bit 0, take the lowest set bit, then map back
  always_comb begin
    dbl = {req_i, req_i};
    rot = N'(dbl >> ptr_i);
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = (IDX_W+1)'(i);
    end
    sum = off + (IDX_W+1)'(ptr_i);
    if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
    idx_o   = sum[IDX_W-1:0];
    valid_o = |req_i;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one single-port data memory between cores
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUS_W     = BUS_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_CORES);

  arb_state_t           state_q;
  logic                 mem_we_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [DATA_W-1:0]    mem_wdata_q;
  logic [NUM_CORES-1:0] core_ack_q;
  logic                 busy_q;
  logic [IDX_W-1:0]     grant_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     rr_ptr_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;

  rr_picker #(.N(NUM_CORES)) u_picker (
    .req_i   (bus.core_req),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Steer the candidate winner's operands toward the command registers
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_we    = bus.core_we[i];
        sel_addr  = bus.core_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.core_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next rotation start: one past the core being acknowledged
  always_comb begin
    rr_ptr_d = grant_q + IDX_W'(1);
    if (grant_q == IDX_W'(NUM_CORES - 1)) rr_ptr_d = '0;
  end

  // Arbitration FSM: latch winner in IDLE, let memory act in ACCESS, acknowledge in RESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_ack_q  <= '0;
      busy_q      <= 1'b0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            grant_q     <= pick_idx;
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          // The memory has consumed the command at this edge; the ack is
          // raised now so it is a clean register output during RESP.
          mem_we_q   <= 1'b0;
          core_ack_q <= NUM_CORES'(1) << grant_q;
          state_q    <= RESP;
        end
        RESP: begin
          core_ack_q <= '0;
          busy_q     <= 1'b0;
          rr_ptr_q   <= rr_ptr_d;
          state_q    <= IDLE;
        end
        default: begin
          mem_we_q   <= 1'b0;
          core_ack_q <= '0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = {{(BUS_W-DATA_W){1'b0}}, mem_wdata_q};
  assign bus.core_ack   = core_ack_q;
  assign bus.core_rdata = bus.mem_rdata;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = grant_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter that shares the single-port 4096x12 data memory between `NUM_CORES` processing cores in the multi-core build. It accepts at most one access at a time. It latches the winning core's request, drives the memory's `write_en`/`addr`/`datain` from registers, captures the memory's one-cycle-latency `dataout`, and returns it to the winner with a one-cycle acknowledge. It sits between the core array and `datamemory`; it is the only block that drives the memory ports.

## Interface
- `NUM_CORES`, default 4: number of requesters (2..8).
- `ADDR_W`, default 12: memory address width.
- `DATA_W`, default 12: memory word width.
- `BUS_W`, default 17: width of the memory `datain` port.

Ports:
- `clk`, in, 1: sole clock. All state changes on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `core_req`, in, `NUM_CORES`: per-core request. Held with its operands until that core's ack.
- `core_we`, in, `NUM_CORES`: 1 = write, 0 = read.
- `core_addr`, in, `NUM_CORES*ADDR_W`: packed addresses; core i uses bits [i*ADDR_W +: ADDR_W].
- `core_wdata`, in, `NUM_CORES*DATA_W`: packed write data, same packing as `core_addr`.
- `core_ack`, out, `NUM_CORES`: one-hot, one-cycle completion pulse.
- `core_rdata`, out, `DATA_W`: read data, broadcast to all cores. Valid only while the matching `core_ack` bit is high.
- `mem_we`, out, 1: to memory `write_en`.
- `mem_addr`, out, `ADDR_W`: to memory `addr`.
- `mem_wdata`, out, `BUS_W`: to memory `datain`. The upper `BUS_W-DATA_W` bits are always 0.
- `mem_rdata`, in, `DATA_W`: from memory `dataout`.
- `busy`, out, 1: high in ACCESS and RESP.
- `grant_id`, out, `$clog2(NUM_CORES)`: index of the current or last winner.

## Operation
The FSM has three states: IDLE, ACCESS and RESP.

- **IDLE**
  - If `core_req` is 0, stay in IDLE.
  - Otherwise pick a winner by round-robin. Search starts at `rr_ptr` and wraps modulo `NUM_CORES`.
  - Latch the winner's `we`, `addr` and `wdata` into `mem_we`, `mem_addr` and `mem_wdata`.
  - Set `grant_id` to the winner and move to ACCESS.
- **ACCESS**
  - The memory sees the registered command this cycle and writes or reads at the closing edge.
  - `mem_we` is cleared at that edge. The FSM moves to RESP.
- **RESP**
  - `core_ack[grant_id]` = 1.
  - `core_rdata` = `mem_rdata` (combinational pass-through). For writes it is don't-care.
  - `rr_ptr` ← `grant_id`+1 mod `NUM_CORES`. Return to IDLE.
- **Request sampling**
  - `core_req` is sampled only in IDLE. A core deasserts `req` on the edge after its ack, or keeps it high to issue a new access.
  - A core may drop `req` before being granted; no access results.
  - Operand changes after the IDLE latch are ignored.
- **Address range:** all `ADDR_W` values are legal, including 0 and 4095. There are no reserved addresses.

## Timing
- **Per-access sequence:** request sampled in cycle T (IDLE), memory access in T+1, ack in T+2, IDLE again in T+3.
- **Latency and throughput:** 2 cycles from grant to ack. Peak throughput is one access per 3 cycles.
- **Reset values** (after any edge with `rst_n`=0):
  - state = IDLE.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `core_ack`=0, `busy`=0, `grant_id`=0, `rr_ptr`=0.
  - `core_rdata` follows `mem_rdata` but is qualified only by ack.
- **Reset mid-operation:**
  - A write whose ACCESS cycle coincides with `rst_n`=0 still commits in memory, because the memory has no reset. No ack is issued.
  - Reset during RESP suppresses nothing already driven that cycle. The FSM restarts in IDLE.
- **Simultaneous requests:** with all cores requesting continuously, grants rotate 0,1,2,…,`NUM_CORES`-1,0. No core waits more than `NUM_CORES` transactions.
- **Back-to-back requests:** a core that holds `req` through its ack is re-eligible at T+3, but only after the other pending cores in rotation order.

## Structure
- **Package `dmem_pkg`** holds:
  - the `ADDR_W`/`DATA_W`/`BUS_W` defaults;
  - the state enum `arb_state_t` {IDLE, ACCESS, RESP};
  - the command struct {we, addr, wdata}.
- **Sub-module `rr_picker`:** purely combinational.
  - Inputs: `req` vector and `rr_ptr`.
  - Outputs: `valid` and winner index.
  - Implemented as a rotate, then priority-encode, then un-rotate.
- **Top level:** the FSM, the command registers and `rr_ptr` live in `dmem_arbiter`.

## Test plan
- **Single write then read:** reset, then core 2 writes 12'hABC to addr 100.
  - Required: `mem_we`=1 with `mem_addr`=100 and `mem_wdata`=17'h00ABC in T+1; `core_ack`=4'b0100 in T+2.
  - Then core 2 reads addr 100: `core_rdata`=12'hABC with the ack.
- **Full contention:** all 4 cores request reads continuously.
  - Required: grant order 0,1,2,3,0,1; acks exactly 3 cycles apart.
- **Pointer wrap:** core 3 is served, then cores 0 and 3 request together.
  - Required: core 0 wins first.
- **Boundary addresses:** write and read back addr 0 and addr 4095 with data 12'hFFF and 12'h001.
  - Required: exact readback; `mem_wdata`[16:12]=0 throughout.
- **Reset mid-write:** assert `rst_n`=0 during ACCESS of a write to addr 7.
  - Required: no ack; all outputs at reset values next cycle.
  - A subsequent read of addr 7 returns the written data.
- **Withdrawn request:** core 1 raises `req` while busy, then drops it before IDLE.
  - Required: no grant to core 1 and `mem_we` stays 0.
